svnet_fifo_arbiter: RTL and testbench

Round-robin write arbiter that shares one FIFO write port (free_space / write / write_data step interface) between N requesters. It sits in front of a shared buffer FIFO and collects results from parallel convolution lanes into one stream. Each accepted beat is tagged with its source index. Optional burst locking keeps a multi-beat packet contiguous.

---
 rtl/svnet_arbiter_pkg.sv | 42 ++++
 rtl/svnet_fifo_arbiter_if.sv | 29 ++
 rtl/svnet_rr_picker.sv | 23 ++
 rtl/svnet_fifo_arbiter.sv | 113 +++++++++++
 tb/tb_svnet_fifo_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/svnet_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the svnet arbiters.
// Used by svnet_fifo_arbiter and svnet_rr_picker.
package svnet_arbiter_pkg;

  localparam int MAX_N = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Rotate by ptr, take the lowest set bit, then map back to a real index.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_N-1:0] req,
    input logic [IDX_W-1:0] ptr,
    input int               n
  );
    rr_pick_t         r;
    logic [MAX_N-1:0] rot;
    logic [IDX_W-1:0] k;
    r   = '0;
    rot = '0;
    for (int i = 0; i < MAX_N; i++) begin
      k = IDX_W'((int'(ptr) + i) % n);
      if (i < n) rot[i] = req[k];
    end
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'((int'(ptr) + i) % n);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/svnet_fifo_arbiter_if.sv
// Requester / FIFO write-port bundle for svnet_fifo_arbiter.
// master drives requests and free space, slave is the arbiter.
interface svnet_fifo_arbiter_if #(
  parameter int N      = 2,
  parameter int WIDTH  = 1,
  parameter int FREE_W = 1
);
  localparam int IW = $clog2(N);

  logic [N-1:0]      req;
  logic [WIDTH-1:0]  req_data [N];
  logic [N-1:0]      req_last;
  logic [N-1:0]      grant;
  logic [FREE_W-1:0] fifo_free_space;
  logic              fifo_write;
  logic [WIDTH-1:0]  fifo_write_data;
  logic [IW-1:0]     fifo_write_id;

  modport master (
    output req, req_data, req_last, fifo_free_space,
    input  grant, fifo_write, fifo_write_data, fifo_write_id
  );

  modport slave (
    input  req, req_data, req_last, fifo_free_space,
    output grant, fifo_write, fifo_write_data, fifo_write_id
  );

endinterface

// File: rtl/svnet_rr_picker.sv
// Combinational round-robin picker: rotate, priority-encode, unrotate.
// Search starts at ptr and wraps modulo N.
module svnet_rr_picker
  import svnet_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  rr_pick_t r;

  always_comb begin
    r     = rr_pick(MAX_N'(req), IDX_W'(ptr), N);
    found = r.found;
    idx   = r.idx[IW-1:0];
  end

endmodule

// File: rtl/svnet_fifo_arbiter.sv
// Round-robin N:1 arbiter onto one FIFO write port, beats tagged by source.
// Burst locking is built when SVNET_FIFO_ARBITER_LOCK_EN is defined.
module svnet_fifo_arbiter
  import svnet_arbiter_pkg::*;
#(
  parameter  int N         = 2,
  parameter  int WIDTH     = 1,
  parameter  int FREE_W    = 1,
  parameter  int MAX_BURST = 16,
  localparam int IW        = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  svnet_fifo_arbiter_if.slave  bus,
  output logic                 locked,
  output logic [IW-1:0]        owner
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] pick;
  logic [IW-1:0] nxt;
  logic [N-1:0]  elig;
  logic          found;
  logic          take;

  svnet_rr_picker #(.N(N)) u_pick (
    .req   (elig),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  // rst_n gates the grant so nothing is written while in reset.
  assign take = rst_n & found & (|bus.fifo_free_space);
  assign nxt  = (pick == IW'(N - 1)) ? '0 : pick + 1'b1;

  always_comb begin
    bus.grant = '0;
    if (take) bus.grant[pick] = 1'b1;
  end

  assign bus.fifo_write      = take;
  assign bus.fifo_write_data = bus.req_data[pick];
  assign bus.fifo_write_id   = pick;

`ifdef SVNET_FIFO_ARBITER_LOCK_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = (beat_cnt == CW'(MAX_BURST)) ? beat_cnt
                                                : beat_cnt + 1'b1;

  // While locked only the owner may win, even if that leaves a bubble.
  assign elig = (state == ARB_LOCKED) ? (bus.req & (N'(1) << owner))
                                      : bus.req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      owner    <= '0;
      locked   <= 1'b0;
      beat_cnt <= '0;
    end else if (take) begin
      ptr <= nxt;
      unique case (state)
        ARB_IDLE: begin
          owner <= pick;
          if (!bus.req_last[pick] && MAX_BURST > 1) begin
            state    <= ARB_LOCKED;
            locked   <= 1'b1;
            beat_cnt <= CW'(1);
          end
        end
        ARB_LOCKED: begin
          beat_cnt <= cnt_inc;
          if (bus.req_last[pick] || cnt_inc == CW'(MAX_BURST)) begin
            state    <= ARB_IDLE;
            locked   <= 1'b0;
            beat_cnt <= '0;
          end
        end
      endcase
    end
  end

  a_owner_only: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ARB_LOCKED) |-> ((bus.grant & ~(N'(1) << owner)) == '0));
`else
  assign elig   = bus.req;
  assign locked = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      owner <= '0;
    end else if (take) begin
      ptr   <= nxt;
      owner <= pick;
    end
  end
`endif

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.grant));

  a_space: assert property (@(posedge clk) disable iff (!rst_n)
    bus.fifo_write |-> (bus.fifo_free_space != '0));

endmodule

// File: tb/tb_svnet_fifo_arbiter.sv
// Bench for svnet_fifo_arbiter: directed table, lock corner cases,
// reset abort, and random traffic against a behavioural model.
module tb_svnet_fifo_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int FW = 4;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic [1:0] owner;

  int checks = 0;
  int errors = 0;

  int m_ptr, m_owner, m_cnt;
  bit m_lock;

  svnet_fifo_arbiter_if #(.N(N), .WIDTH(W), .FREE_W(FW)) bus ();

  svnet_fifo_arbiter #(
    .N(N), .WIDTH(W), .FREE_W(FW), .MAX_BURST(MB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .locked (locked),
    .owner  (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_lock = 0;
  endtask

  // Called just after a rising edge; checks mid-cycle, then advances.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l,
                       input int free, output logic [N-1:0] g);
    logic [W-1:0] d [N];
    bit hit;
    int j;
    bus.req = r;
    bus.req_last = l;
    bus.fifo_free_space = FW'(free);
    for (int i = 0; i < N; i++) begin
      d[i] = W'($urandom);
      bus.req_data[i] = d[i];
    end
    #4;
    hit = 0;
    j = 0;
    if (free != 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!hit && r[c] && (!m_lock || c == m_owner)) begin
          hit = 1;
          j = c;
        end
      end
    end
    g = bus.grant;
    chk("grant", bus.grant, hit ? (1 << j) : 0);
    chk("fifo_write", bus.fifo_write, hit);
    if (hit) begin
      chk("write_id", bus.fifo_write_id, j);
      chk("write_data", bus.fifo_write_data, d[j]);
    end
    chk("locked", locked, m_lock);
    chk("owner", owner, m_owner);
    @(posedge clk);
    #1;
    if (hit) begin
      m_ptr = (j + 1) % N;
`ifdef SVNET_FIFO_ARBITER_LOCK_EN
      if (!m_lock) begin
        m_owner = j;
        if (!l[j]) begin
          m_lock = 1;
          m_cnt = 1;
        end
      end else begin
        m_cnt++;
        if (l[j] || m_cnt >= MB) begin
          m_lock = 0;
          m_cnt = 0;
        end
      end
`else
      m_owner = j;
`endif
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                      input int free, input logic [N-1:0] eg,
                      input string nm);
    logic [N-1:0] g;
    cycle(r, l, free, g);
    chk(nm, g, eg);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] last;
    int           free;
    logic [N-1:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [N-1:0] g;
    int lk;

    tbl[0]  = '{4'b1111, 4'b1111, 8, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b1111, 8, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b1111, 8, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1111, 8, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b1111, 8, 4'b0001};
    tbl[5]  = '{4'b1000, 4'b1111, 8, 4'b1000};
    tbl[6]  = '{4'b0101, 4'b1111, 0, 4'b0000};
    tbl[7]  = '{4'b0101, 4'b1111, 0, 4'b0000};
    tbl[8]  = '{4'b0101, 4'b1111, 0, 4'b0000};
    tbl[9]  = '{4'b0101, 4'b1111, 8, 4'b0001};
    tbl[10] = '{4'b0101, 4'b1111, 8, 4'b0100};

    rst_n = 1'b0;
    bus.req = '0;
    bus.req_last = '0;
    bus.fifo_free_space = '0;
    for (int i = 0; i < N; i++) bus.req_data[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", bus.grant, 0);
    chk("reset_write", bus.fifo_write, 0);
    chk("reset_locked", locked, 0);
    chk("reset_owner", owner, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      step(tbl[i].req, tbl[i].last, tbl[i].free, tbl[i].exp, "table");

`ifdef SVNET_FIFO_ARBITER_LOCK_EN
    // 4-beat packet from 1 while 2 waits.
    lk = 0;
    for (int b = 0; b < 3; b++) begin
      step(4'b0110, 4'b0100, 8, 4'b0010, "pkt_beat");
      lk += int'(locked);
    end
    step(4'b0110, 4'b0110, 8, 4'b0010, "pkt_last");
    lk += int'(locked);
    step(4'b0100, 4'b0100, 8, 4'b0100, "after_pkt");
    lk += int'(locked);
    chk("locked_cycles", lk, 3);

    // Forced release after MB beats, waiting requester 3 served next.
    step(4'b1000, 4'b1000, 8, 4'b1000, "park_ptr");
    for (int b = 0; b < MB; b++)
      step(4'b1001, 4'b1000, 8, 4'b0001, "burst_beat");
    chk("forced_release", locked, 0);
    step(4'b1001, 4'b1000, 8, 4'b1000, "waiter");
    step(4'b1001, 4'b1000, 8, 4'b0001, "resume");
    chk("relock", locked, 1);
    step(4'b0001, 4'b0001, 8, 4'b0001, "resume_last");

    // Owner 2 stalls; requester 0 must not be granted.
    step(4'b0101, 4'b0001, 8, 4'b0100, "own2_start");
    step(4'b0001, 4'b0001, 8, 4'b0000, "bubble1");
    step(4'b0001, 4'b0001, 8, 4'b0000, "bubble2");
    step(4'b0101, 4'b0100, 8, 4'b0100, "own2_last");
    step(4'b0001, 4'b0001, 8, 4'b0001, "req0_after");
`endif

    // Reset pulsed in the middle of a (lock build) burst.
    step(4'b0010, 4'b0000, 8, 4'b0010, "pre_reset");
`ifdef SVNET_FIFO_ARBITER_LOCK_EN
    chk("pre_reset_locked", locked, 1);
`endif
    bus.req = 4'b0010;
    bus.fifo_free_space = FW'(8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_write", bus.fifo_write, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_owner", owner, 0);
    rst_n = 1'b1;
    step(4'b1111, 4'b1111, 8, 4'b0001, "ptr_after_rst");

    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] r, l;
      int f;
      r = N'($urandom);
      l = ~(N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
      f = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 8));
      cycle(r, l, f, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
